aibcr3aux_dlycal_ctrl: RTL and testbench
========================================

// Module: aibcr3aux_dlycal_ctrl
// PURPOSE
//  Delay-calibration controller that drives csr_dly_ovrd[3:0] and csr_dly_ovrden of the aux
//  strobe clock tree's output clock delay stage (strbclk25 path).
//  Linear sweep of the delay code using an averaged phase-detector sample, locks the code, then
//  optionally tracks drift. A CSR bypass lets software force the code directly.
// PARAMETERS
//  CODE_W      4  delay code width; max code = 2^CODE_W-1
//  AVG_W       4  log2 of phase-detector samples accumulated per decision (16)
//  SETTLE_CYC  8  cycles waited after any code change before sampling (>=1)
//  TRACK_EN    1  1 = keep adjusting after lock; 0 = freeze code at lock
// PORTS
//  clk          in   1       controller clock (aux oscillator domain)
//  rst_n        in   1       async active-low reset
//  cal_start    in   1       1-cycle start/restart pulse
//  cal_bypass   in   1       1 = CSR override; code taken from csr_code_in
//  csr_code_in  in   CODE_W  software delay code used in bypass
//  pd_late      in   1       phase-detector sample, already synchronized to clk; 1 = delayed clk late
//  dly_code     out  CODE_W  to clock-tree csr_dly_ovrd
//  dly_ovrden   out  1       to clock-tree csr_dly_ovrden
//  cal_busy     out  1       sweep in progress
//  cal_done     out  1       code locked (sticky until restart/bypass/reset)
//  cal_err      out  1       sweep hit max code without late detect (sticky)
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, all counters 0. Outputs are registered.
//  States: IDLE, SETTLE, SAMPLE, DECIDE, LOCK, ERR.
//  IDLE: on cal_start -> SETTLE next cycle with dly_code=0, dly_ovrden=1, cal_busy=1,
//    cal_done=0, cal_err=0.
//  SETTLE: count SETTLE_CYC cycles, then SAMPLE. Settle counter clears on entry.
//  SAMPLE: 2^AVG_W cycles; late_cnt (AVG_W+1 bits) += pd_late each cycle; -> DECIDE.
//  DECIDE (1 cycle), sweep mode, late = late_cnt > 2^(AVG_W-1) (strict majority):
//    late -> LOCK; code unchanged; cal_busy=0, cal_done=1.
//    not late, code<max -> code+1, -> SETTLE.
//    not late, code==max -> ERR; code held at max; cal_busy=0, cal_err=1.
//  Sweep step = SETTLE_CYC + 2^AVG_W + 1 cycles (25 at defaults).
//  Code 0 already late: lock at 0 after one step.
//  LOCK, TRACK_EN=1: repeat SETTLE/SAMPLE/DECIDE in tracking mode; cal_done stays 1, cal_busy stays 0.
//    late_cnt < 2^(AVG_W-2) -> code+1, saturate at max.
//    late_cnt > 3*2^(AVG_W-2) -> code-1, saturate at 0.
//    Otherwise hold (hysteresis band). Tracking never sets cal_err.
//  LOCK, TRACK_EN=0: code frozen, no sampling.
//  LOCK/ERR + cal_start: restart sweep exactly as from IDLE.
//  cal_start during sweep (cal_busy=1): ignored.
//  cal_bypass=1: takes priority in every state.
//    Same cycle (registered): dly_code=csr_code_in, dly_ovrden=1.
//    FSM forced to IDLE, counters cleared, busy/done/err=0.
//    While bypass is high, cal_start is ignored and csr_code_in changes are followed with 1-cycle latency.
//  Bypass deassert: FSM IDLE; dly_code holds last csr value, dly_ovrden holds 1 until next cal_start.
//  rst_n assert mid-sweep: immediate return to reset values (ovrden=0, code=0).
//  Code changes only on DECIDE or bypass, so it never toggles more than once per step.
// TESTING
//  1 Reset then idle: cal_start never pulsed -> all outputs 0 for 100 cycles.
//  2 pd_late=0 for codes 0..5, 1 from code 6 -> cal_done=1, dly_code=6,
//    busy high for exactly 7*25=175 cycles.
//  3 pd_late stuck 0 -> after 16 steps (400 cycles) cal_err=1, dly_code=15, cal_done=0.
//  4 After lock at 6, TRACK_EN=1: pd_late=0 -> code 7 after 25 cycles; pd_late=1 -> back to 6;
//    pd_late alternating 1/0 (late_cnt=8) -> code holds.
//  5 cal_bypass=1 with csr_code_in=9 mid-sweep -> next cycle dly_code=9, ovrden=1,
//    busy/done/err=0; cal_start pulses ignored.
//  6 rst_n low during SAMPLE at code 3 -> outputs 0 immediately;
//    cal_start after release restarts sweep at code 0.

Source files
------------

// File: rtl/aibcr3aux_dlycal_ctrl.sv
// rtl/aibcr3aux_dlycal_ctrl.sv - delay-calibration controller for the aux strobe clock delay stage
module aibcr3aux_dlycal_ctrl #(
    parameter int CODE_W     = 4,
    parameter int AVG_W      = 4,
    parameter int SETTLE_CYC = 8,
    parameter int TRACK_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cal_start,
    input  logic              cal_bypass,
    input  logic [CODE_W-1:0] csr_code_in,
    input  logic              pd_late,
    output logic [CODE_W-1:0] dly_code,
    output logic              dly_ovrden,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              cal_err
);

    localparam int CNT_W = $clog2(SETTLE_CYC + (1 << AVG_W)) + 1;
    localparam int LAT_W = AVG_W + 1;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'((1 << AVG_W) - 1);
    localparam logic [LAT_W-1:0]  LATE_MAJ    = LAT_W'(1 << (AVG_W - 1));
    localparam logic [LAT_W-1:0]  TRK_LO      = LAT_W'(1 << (AVG_W - 2));
    localparam logic [LAT_W-1:0]  TRK_HI      = LAT_W'(3 * (1 << (AVG_W - 2)));
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DECIDE,
        LOCK,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  late_q, late_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ovrden_q, ovrden_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              track_q, track_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            late_q   <= '0;
            code_q   <= '0;
            ovrden_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            track_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            late_q   <= late_d;
            code_q   <= code_d;
            ovrden_q <= ovrden_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            track_q  <= track_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        late_d   = late_q;
        code_d   = code_q;
        ovrden_d = ovrden_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        track_d  = track_q;

        if (cal_bypass) begin
            state_d  = IDLE;
            cnt_d    = '0;
            late_d   = '0;
            code_d   = csr_code_in;
            ovrden_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            track_d  = 1'b0;
        end else if (cal_start && !busy_q) begin
            // Restart is accepted from idle, lock (incl. tracking) and error alike.
            state_d  = SETTLE;
            cnt_d    = '0;
            late_d   = '0;
            code_d   = '0;
            ovrden_d = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            err_d    = 1'b0;
            track_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        late_d  = '0;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    late_d = late_q + LAT_W'(pd_late);
                    if (cnt_q == SAMPLE_LAST) begin
                        cnt_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DECIDE: begin
                    if (!track_q) begin
                        if (late_q > LATE_MAJ) begin
                            state_d = LOCK;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (code_q != CODE_MAX) begin
                            code_d  = code_q + 1'b1;
                            state_d = SETTLE;
                        end else begin
                            state_d = ERR;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end
                    end else begin
                        // Hysteresis band between TRK_LO and TRK_HI holds the code.
                        if (late_q < TRK_LO && code_q != CODE_MAX) begin
                            code_d = code_q + 1'b1;
                        end else if (late_q > TRK_HI && code_q != '0) begin
                            code_d = code_q - 1'b1;
                        end
                        state_d = SETTLE;
                    end
                end
                LOCK: begin
                    if (TRACK_EN != 0) begin
                        track_d = 1'b1;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                ERR: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign dly_code   = code_q;
    assign dly_ovrden = ovrden_q;
    assign cal_busy   = busy_q;
    assign cal_done   = done_q;
    assign cal_err    = err_q;

endmodule

// File: tb/tb_aibcr3aux_dlycal_ctrl.sv
// tb/tb_aibcr3aux_dlycal_ctrl.sv - scoreboard bench for aibcr3aux_dlycal_ctrl
`timescale 1ns/1ps
module tb_aibcr3aux_dlycal_ctrl;

    localparam int STEP = 8 + 16 + 1;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       cal_start   = 1'b0;
    logic       cal_bypass  = 1'b0;
    logic [3:0] csr_code_in = 4'd0;
    logic       pd_late     = 1'b0;
    logic [3:0] dly_code;
    logic       dly_ovrden;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_err;

    always #5 clk = ~clk;

    aibcr3aux_dlycal_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cal_start   (cal_start),
        .cal_bypass  (cal_bypass),
        .csr_code_in (csr_code_in),
        .pd_late     (pd_late),
        .dly_code    (dly_code),
        .dly_ovrden  (dly_ovrden),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .cal_err     (cal_err)
    );

    typedef struct {
        int         t;
        logic [7:0] v;
    } ev_t;

    ev_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         mode     = 3;
    int         thr      = 16;
    bit         mon_en   = 1'b0;
    logic [7:0] prev_v   = 8'd0;
    int         tab[4]   = '{6, 16, 0, 15};

    always @(posedge clk) cyc <= cyc + 1;

    // Phase-detector plant: threshold on current code, constant, or alternating.
    always @(negedge clk) begin
        case (mode)
            0:       pd_late = (int'(dly_code) >= thr);
            1:       pd_late = 1'b0;
            2:       pd_late = 1'b1;
            default: pd_late = ~pd_late;
        endcase
    end

    always @(negedge clk) begin
        logic [7:0] cur;
        ev_t        e;
        cur = {dly_code, dly_ovrden, cal_busy, cal_done, cal_err};
        if (mon_en && cur !== prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected cyc=%0d got=%h required=no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.v) begin
                    failures++;
                    $display("FAIL sb_value cyc=%0d got=%h required=%h", cyc, cur, e.v);
                end
                if (e.t >= 0) begin
                    checks++;
                    if (cyc != e.t) begin
                        failures++;
                        $display("FAIL sb_time value=%h got_cyc=%0d required_cyc=%0d", cur, cyc, e.t);
                    end
                end
            end
        end
        prev_v = cur;
    end

    function automatic logic [7:0] pack(input int code, input bit ov, input bit b, input bit d, input bit e);
        return {4'(code), ov, b, d, e};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int t, input logic [7:0] v);
        ev_t e;
        e.t = t;
        e.v = v;
        exp_q.push_back(e);
    endtask

    // Linear sweep: late once code >= th; th > 15 never goes late.
    task automatic push_sweep(input int s, input int th, input int stop);
        int nsteps;
        int t;
        nsteps = (th > 15) ? 16 : th + 1;
        if (s + 1 <= stop) push(s + 1, pack(0, 1, 1, 0, 0));
        for (int c = 1; c < nsteps; c++)
            if (s + 1 + STEP * c <= stop) push(s + 1 + STEP * c, pack(c, 1, 1, 0, 0));
        t = s + 1 + STEP * nsteps;
        if (t <= stop) push(t, (th > 15) ? pack(15, 1, 0, 0, 1) : pack(th, 1, 0, 1, 0));
    endtask

    task automatic pulse_start(input int th, input int stop_off, output int s);
        @(negedge clk);
        thr       = th;
        cal_start = 1'b1;
        s         = cyc;
        push_sweep(s, th, s + stop_off);
        @(negedge clk);
        cal_start = 1'b0;
    endtask

    task automatic wait_not_busy(input int bound);
        int n;
        n = 0;
        while (cal_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop_timeout", int'(cal_busy), 0);
    endtask

    task automatic wait_code(input int val, input int bound);
        int n;
        n = 0;
        while (int'(dly_code) != val && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("track_code_timeout", int'(dly_code), val);
    endtask

    initial begin
        int s;
        int th;
        int nv;
        int k;

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            repeat (25) @(negedge clk);
            check("idle_outputs", int'({dly_code, dly_ovrden, cal_busy, cal_done, cal_err}), 0);
        end

        for (int it = 0; it < 8; it++) begin
            th   = (it < 4) ? tab[it] : int'($urandom_range(0, 16));
            mode = 0;
            pulse_start(th, 100000, s);
            wait_not_busy(450);
            check("sweep_busy_len", cyc - s - 1, STEP * ((th > 15) ? 16 : th + 1));
            check("sweep_done", int'(cal_done), (th <= 15) ? 1 : 0);
            check("sweep_err", int'(cal_err), (th > 15) ? 1 : 0);
            check("sweep_code", int'(dly_code), (th > 15) ? 15 : th);
            if (it == 0) begin
                mode = 1;
                push(-1, pack(7, 1, 0, 1, 0));
                wait_code(7, 80);
                mode = 2;
                push(-1, pack(6, 1, 0, 1, 0));
                wait_code(6, 80);
                mode = 3;
                repeat (100) @(negedge clk);
                check("track_hold_code", int'(dly_code), 6);
            end else if (th == 0) begin
                mode = 2;
                repeat (80) @(negedge clk);
                check("track_sat_low", int'(dly_code), 0);
            end else if (th == 15) begin
                mode = 1;
                repeat (80) @(negedge clk);
                check("track_sat_high", int'(dly_code), 15);
            end else begin
                mode = 3;
                repeat (30) @(negedge clk);
            end
        end

        mode = 1;
        k    = int'($urandom_range(30, 200));
        pulse_start(16, k, s);
        while (cyc < s + k) @(negedge clk);
        cal_bypass  = 1'b1;
        csr_code_in = 4'd9;
        push(cyc + 1, pack(9, 1, 0, 0, 0));
        @(negedge clk);
        check("bypass_code", int'(dly_code), 9);
        check("bypass_flags", int'({dly_ovrden, cal_busy, cal_done, cal_err}), 8);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            nv = int'($urandom_range(0, 15));
            if (nv != int'(csr_code_in)) push(cyc + 1, pack(nv, 1, 0, 0, 0));
            csr_code_in = 4'(nv);
            cal_start   = 1'b1;
            @(negedge clk);
            cal_start = 1'b0;
        end
        @(negedge clk);
        cal_bypass = 1'b0;
        repeat (50) @(negedge clk);
        check("bypass_hold_code", int'(dly_code), int'(csr_code_in));
        check("bypass_hold_flags", int'({dly_ovrden, cal_busy, cal_done, cal_err}), 8);

        mode = 1;
        pulse_start(16, 88, s);
        do begin
            @(posedge clk);
            #2;
        end while (cyc < s + 90);
        rst_n = 1'b0;
        push(cyc, pack(0, 0, 0, 0, 0));
        #1;
        check("reset_code", int'(dly_code), 0);
        check("reset_flags", int'({dly_ovrden, cal_busy, cal_done, cal_err}), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        pulse_start(5, 100000, s);
        wait_not_busy(450);
        check("post_reset_code", int'(dly_code), 5);
        check("post_reset_done", int'(cal_done), 1);
        mode = 3;

        repeat (10) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
